// File: rtl/nx_round_sequencer_pkg.sv
// Shared types and constants for the NOR-XOR round sequencer.
package nx_seq_pkg;

    localparam int NX_W = 8;
    localparam logic [NX_W-1:0] NX_STATE_RST = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

endpackage

// File: rtl/nx_round_sequencer_if.sv
// Job handshake between the tile I/O wrapper (master) and the round sequencer (slave).
interface nx_round_sequencer_if #(
    parameter int ROUND_W = 4
);
    import nx_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [NX_W-1:0]    din;
    logic [ROUND_W-1:0] num_rounds;
    logic               out_valid;
    logic               out_ready;
    logic [NX_W-1:0]    dout;
    logic               busy;

    modport master (
        output in_valid, din, num_rounds, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, din, num_rounds, out_ready,
        output in_ready, out_valid, dout, busy
    );

endinterface

// File: rtl/nx_round_sequencer_mix8.sv
// nx_mix8: one combinational round of the 8-bit NOR-XOR mixing network.
module nx_mix8 (
    input  logic [7:0] x,
    output logic [7:0] y
);

    function automatic logic nor2(input logic a, input logic b);
        return ~(a | b);
    endfunction

    // Later taps feed on earlier outputs, so keep them as scalars to avoid a self-referencing vector.
    logic y0, y1, y2, y3, y4, y5, y6, y7;

    assign y6 = x[4] ^ nor2(x[7], x[6]);
    assign y2 = x[6] ^ nor2(x[2], x[1]);
    assign y5 = x[0] ^ nor2(x[3], x[2]);
    assign y7 = x[5] ^ nor2(y6, y5);
    assign y3 = x[1] ^ nor2(y5, x[3]);
    assign y4 = x[3] ^ nor2(y7, y6);
    assign y1 = x[7] ^ nor2(y2, y7);
    assign y0 = x[2] ^ nor2(y3, y1);

    assign y = {y7, y6, y5, y4, y3, y2, y1, y0};

endmodule

// File: rtl/nx_round_sequencer.sv
// Round sequencer for nx_mix8: one mix round per clock, result held until taken.
// Build option NX_ROUND_KEY_EN: XOR the round index into the state before each round.
//
// state | meaning
// IDLE  | ready for a job; in_ready high
// RUN   | applying one mix round per clock; busy high
// HOLD  | result in dout; out_valid high until out_ready
module nx_round_sequencer
    import nx_seq_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nx_round_sequencer_if.slave   bus
);

    seq_state_e         fsm_q, fsm_d;
    logic [NX_W-1:0]    state_q, state_d;
    logic [ROUND_W-1:0] cnt_q, cnt_d;
    logic [NX_W-1:0]    mix_x, mix_y;

`ifdef NX_ROUND_KEY_EN
    logic [ROUND_W-1:0] ridx_q, ridx_d;

    assign mix_x = state_q ^ {{(NX_W-ROUND_W){1'b0}}, ridx_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ridx_q <= '0;
        end else begin
            ridx_q <= ridx_d;
        end
    end

    always_comb begin
        ridx_d = ridx_q;
        if (fsm_q == ST_IDLE && bus.in_valid) begin
            ridx_d = '0;
        end else if (fsm_q == ST_RUN) begin
            ridx_d = ridx_q + ROUND_W'(1);
        end
    end
`else
    assign mix_x = state_q;
`endif

    nx_mix8 u_mix (
        .x (mix_x),
        .y (mix_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= NX_STATE_RST;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.din;
                    cnt_d   = bus.num_rounds;
                    fsm_d   = (bus.num_rounds != '0) ? ST_RUN : ST_HOLD;
                end
            end
            ST_RUN: begin
                state_d = mix_y;
                // The counter saturates at zero; RUN is only entered with a non-zero count.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ROUND_W'(1);
                end
                if (cnt_q <= ROUND_W'(1)) begin
                    fsm_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (fsm_q == ST_IDLE);
    assign bus.busy      = (fsm_q == ST_RUN);
    assign bus.out_valid = (fsm_q == ST_HOLD);
    assign bus.dout      = state_q;

endmodule

// File: tb/tb_nx_round_sequencer.sv
// Directed bench for nx_round_sequencer: vector table plus hand-written handshake/reset sequences.
module tb_nx_round_sequencer;

    logic clk;
    logic rst_n;

    nx_round_sequencer_if #(.ROUND_W(4)) bus ();

    nx_round_sequencer #(.ROUND_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [3:0] rounds;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [7:0] d, input logic [3:0] n,
                           input logic [7:0] exp);
        int guard;
        int lat;
        int busy_cnt;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid   = 1'b1;
        bus.din        = d;
        bus.num_rounds = n;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after the accept edge; they must have no effect.
        bus.in_valid   = 1'b0;
        bus.din        = ~d;
        bus.num_rounds = ~n;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.out_valid && lat < 40) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(n));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, " dout"}, 32'(bus.dout), 32'(exp));
        check({tag, " in_ready in HOLD"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid after retire"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready after retire"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"n1 zero seed", 8'h00, 4'd1, 8'h65});
`ifdef NX_ROUND_KEY_EN
        vecs.push_back('{"n2 zero seed", 8'h00, 4'd2, 8'h1D});
        vecs.push_back('{"n3 zero seed", 8'h00, 4'd3, 8'h2B});
`else
        vecs.push_back('{"n2 zero seed", 8'h00, 4'd2, 8'hA4});
        vecs.push_back('{"n3 zero seed", 8'h00, 4'd3, 8'h19});
        vecs.push_back('{"n15 fixed point", 8'hFF, 4'd15, 8'hFF});
`endif
        vecs.push_back('{"n0 passthrough", 8'h5A, 4'd0, 8'h5A});
        vecs.push_back('{"n1 seed 5A", 8'h5A, 4'd1, 8'h5C});
        vecs.push_back('{"n1 seed FF", 8'hFF, 4'd1, 8'hFF});

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.din        = 8'h00;
        bus.num_rounds = 4'd0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset dout", 32'(bus.dout), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_job(vecs[i].name, vecs[i].din, vecs[i].rounds, vecs[i].exp);
        end

        // HOLD stall with in_valid pulses, then retire with a new request present.
        bus.in_valid = 1'b1; bus.din = 8'h00; bus.num_rounds = 4'd1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall dout", 32'(bus.dout), 32'h65);
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid   = ~bus.in_valid;
            bus.din        = 8'h33;
            bus.num_rounds = 4'd2;
            @(posedge clk); @(negedge clk);
        end
        check("stall still holding", 32'(bus.out_valid), 32'd1);
        check("stall dout final", 32'(bus.dout), 32'h65);
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.din = 8'h5A; bus.num_rounds = 4'd1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        check("retire-edge no accept in_ready", 32'(bus.in_ready), 32'd1);
        check("retire-edge no accept busy", 32'(bus.busy), 32'd0);
        check("retire-edge out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("follow-on accepted busy", 32'(bus.busy), 32'd1);
        @(posedge clk); @(negedge clk);
        check("follow-on out_valid", 32'(bus.out_valid), 32'd1);
        check("follow-on dout", 32'(bus.dout), 32'h5C);
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset in the third RUN cycle of a 10-round job.
        bus.in_valid = 1'b1; bus.din = 8'h00; bus.num_rounds = 4'd10;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-run reset in_ready", 32'(bus.in_ready), 32'd1);
        check("mid-run reset busy", 32'(bus.busy), 32'd0);
        check("mid-run reset out_valid", 32'(bus.out_valid), 32'd0);
        check("mid-run reset dout", 32'(bus.dout), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef NX_ROUND_KEY_EN
        run_job("post-reset n2", 8'h00, 4'd2, 8'h1D);
`else
        run_job("post-reset n2", 8'h00, 4'd2, 8'hA4);
`endif

        // Back-to-back N=1 jobs with in_valid and out_ready held high.
        begin
            logic [6:0] exp_rdy;
            logic [6:0] exp_ov;
            int         results;
            exp_rdy = 7'b1001001;
            exp_ov  = 7'b0010010;
            results = 0;
            bus.in_valid = 1'b1; bus.din = 8'h00; bus.num_rounds = 4'd1; bus.out_ready = 1'b1;
            for (int c = 0; c < 7; c++) begin
                check($sformatf("b2b in_ready c%0d", c), 32'(bus.in_ready), 32'(exp_rdy[6-c]));
                check($sformatf("b2b out_valid c%0d", c), 32'(bus.out_valid), 32'(exp_ov[6-c]));
                if (bus.out_valid) begin
                    results++;
                    check($sformatf("b2b dout c%0d", c), 32'(bus.dout), 32'h65);
                end
                @(posedge clk); @(negedge clk);
            end
            check("b2b result count", 32'(results), 32'd2);
            bus.in_valid = 1'b0;
            repeat (4) @(negedge clk);
            bus.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
